// File: rtl/sram_generic_pipe.sv
// sram_generic_pipe
//   Two-port SRAM model with granule write enables, a configurable read
//   pipeline (nlat cycles) with per-port valid strobes, defined cross-port
//   collision behaviour, out-of-range handling and a self-timed clear
//   sequencer that zeroes one word per cycle.
//
// Ports
//   clk            clock, rising edge
//   rstb           asynchronous active-low reset
//   clr            start a clear sequence (honoured only when idle)
//   busy           clear sequence in progress; port requests are dropped
//   rden_N/wren_N  read / write request, port N (write dominates read)
//   be_N           granule write enables, port N
//   addr_N         word address, port N
//   data_N         write data, port N
//   q_N            read data, port N (holds last result between reads)
//   qv_N           one-cycle pulse marking a new read result on q_N
module sram_generic_pipe #(
  parameter int nbits   = 8,
  parameter int nwords  = 8,
  parameter int wgran   = 8,
  parameter int nlat    = 1,
  parameter int rdw_new = 0,
  parameter int naddrb  = $clog2(nwords),
  parameter int nwe     = nbits / wgran
) (
  input  logic              clk,
  input  logic              rstb,
  input  logic              clr,
  output logic              busy,
  input  logic              rden_1,
  input  logic              wren_1,
  input  logic [nwe-1:0]    be_1,
  input  logic [naddrb-1:0] addr_1,
  input  logic [nbits-1:0]  data_1,
  output logic [nbits-1:0]  q_1,
  output logic              qv_1,
  input  logic              rden_2,
  input  logic              wren_2,
  input  logic [nwe-1:0]    be_2,
  input  logic [naddrb-1:0] addr_2,
  input  logic [nbits-1:0]  data_2,
  output logic [nbits-1:0]  q_2,
  output logic              qv_2
);

  localparam bit params_ok = (nlat >= 1) && (nlat <= 4) && (wgran >= 1) &&
                             (nwords >= 2) && ((nbits % wgran) == 0) &&
                             (naddrb == $clog2(nwords)) && (nwe == nbits / wgran);

  generate
    if (!params_ok) begin : g_param_error
      $error("sram_generic_pipe: illegal parameter combination");
    end
  endgenerate

  localparam logic [naddrb:0]   nwords_w  = (naddrb + 1)'(nwords);
  localparam logic [naddrb-1:0] last_addr = naddrb'(nwords - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t            state_q, state_d;
  logic [naddrb-1:0] ptr_q, ptr_d;

  logic [nbits-1:0]  mem_q [nwords];
  logic [nbits-1:0]  mem_d [nwords];

  // Per-port views so both ports share one description of the logic
  logic              rden     [2];
  logic              wren     [2];
  logic [nwe-1:0]    be       [2];
  logic [naddrb-1:0] addr     [2];
  logic [nbits-1:0]  wdata    [2];
  logic              in_range [2];
  logic              wr_go    [2];
  logic              rd_go    [2];
  logic [nbits-1:0]  rd_val   [2];

  logic [nbits-1:0]  pipe_data_q [2][nlat];
  logic [nbits-1:0]  pipe_data_d [2][nlat];
  logic              pipe_v_q    [2][nlat];
  logic              pipe_v_d    [2][nlat];

  assign rden[0]  = rden_1;
  assign rden[1]  = rden_2;
  assign wren[0]  = wren_1;
  assign wren[1]  = wren_2;
  assign be[0]    = be_1;
  assign be[1]    = be_2;
  assign addr[0]  = addr_1;
  assign addr[1]  = addr_2;
  assign wdata[0] = data_1;
  assign wdata[1] = data_2;

  assign busy = (state_q == ST_CLEAR);

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      in_range[p] = ({1'b0, addr[p]} < nwords_w);
      wr_go[p]    = wren[p] & ~busy;
      rd_go[p]    = rden[p] & ~wren[p] & ~busy;
    end
  end

  // Clear sequencer: walks ptr over every word once, then returns to idle
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr) begin
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        if (ptr_q == last_addr) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + naddrb'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Next memory contents. Port 2 is applied before port 1 so that port 1
  // wins on granules both ports enable; the rest merge as a union.
  always_comb begin
    for (int w = 0; w < nwords; w++) begin
      mem_d[w] = mem_q[w];
    end
    if (busy) begin
      mem_d[ptr_q] = '0;
    end
    for (int p = 1; p >= 0; p--) begin
      if (wr_go[p] && in_range[p]) begin
        for (int g = 0; g < nwe; g++) begin
          if (be[p][g]) begin
            mem_d[addr[p]][g*wgran +: wgran] = wdata[p][g*wgran +: wgran];
          end
        end
      end
    end
  end

  // A read sees either the stored word or the post-write word, which
  // already contains any same-edge write from the other port.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd_val[p] = '0;
      if (in_range[p]) begin
        rd_val[p] = (rdw_new != 0) ? mem_d[addr[p]] : mem_q[addr[p]];
      end
    end
  end

  // Read pipeline: valid bits shift every cycle; each data stage only
  // loads when a valid result arrives, so the last stage holds q_N steady.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      pipe_v_d[p][0]    = rd_go[p];
      pipe_data_d[p][0] = rd_go[p] ? rd_val[p] : pipe_data_q[p][0];
      for (int s = 1; s < nlat; s++) begin
        pipe_v_d[p][s]    = pipe_v_q[p][s-1];
        pipe_data_d[p][s] = pipe_v_q[p][s-1] ? pipe_data_q[p][s-1] : pipe_data_q[p][s];
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      for (int w = 0; w < nwords; w++) begin
        mem_q[w] <= '0;
      end
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < nlat; s++) begin
          pipe_v_q[p][s]    <= 1'b0;
          pipe_data_q[p][s] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      for (int w = 0; w < nwords; w++) begin
        mem_q[w] <= mem_d[w];
      end
      for (int p = 0; p < 2; p++) begin
        for (int s = 0; s < nlat; s++) begin
          pipe_v_q[p][s]    <= pipe_v_d[p][s];
          pipe_data_q[p][s] <= pipe_data_d[p][s];
        end
      end
    end
  end

  assign q_1  = pipe_data_q[0][nlat-1];
  assign qv_1 = pipe_v_q[0][nlat-1];
  assign q_2  = pipe_data_q[1][nlat-1];
  assign qv_2 = pipe_v_q[1][nlat-1];

endmodule

// File: tb/tb_sram_generic_pipe.sv
// tb_sram_generic_pipe
//   Drives two instances of sram_generic_pipe with identical stimulus:
//   dut_a (16-bit words, 6 words, nlat=3, old-data read-during-write) and
//   dut_b (same geometry, nlat=1, new-data read-during-write).
//   A behavioural memory model predicts every read result and its arrival
//   cycle; predictions wait in per-channel queues until the DUT delivers.
module tb_sram_generic_pipe;

  logic        clk;
  logic        rstb;
  logic        clr;
  logic        rden_1, wren_1, rden_2, wren_2;
  logic [1:0]  be_1, be_2;
  logic [2:0]  addr_1, addr_2;
  logic [15:0] data_1, data_2;

  logic        busy_a, busy_b;
  logic [15:0] q_a1, q_a2, q_b1, q_b2;
  logic        qv_a1, qv_a2, qv_b1, qv_b2;

  sram_generic_pipe #(
    .nbits(16), .nwords(6), .wgran(8), .nlat(3), .rdw_new(0)
  ) dut_a (
    .clk(clk), .rstb(rstb), .clr(clr), .busy(busy_a),
    .rden_1(rden_1), .wren_1(wren_1), .be_1(be_1), .addr_1(addr_1), .data_1(data_1),
    .q_1(q_a1), .qv_1(qv_a1),
    .rden_2(rden_2), .wren_2(wren_2), .be_2(be_2), .addr_2(addr_2), .data_2(data_2),
    .q_2(q_a2), .qv_2(qv_a2)
  );

  sram_generic_pipe #(
    .nbits(16), .nwords(6), .wgran(8), .nlat(1), .rdw_new(1)
  ) dut_b (
    .clk(clk), .rstb(rstb), .clr(clr), .busy(busy_b),
    .rden_1(rden_1), .wren_1(wren_1), .be_1(be_1), .addr_1(addr_1), .data_1(data_1),
    .q_1(q_b1), .qv_1(qv_b1),
    .rden_2(rden_2), .wren_2(wren_2), .be_2(be_2), .addr_2(addr_2), .data_2(data_2),
    .q_2(q_b2), .qv_2(qv_b2)
  );

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;

  // channel 0/1 = dut_a port 1/2, channel 2/3 = dut_b port 1/2
  exp_t        sbq [4][$];
  logic        qv_all [4];
  logic [15:0] q_all  [4];

  logic [15:0] model_mem [6];
  logic        model_busy;
  int          model_ptr;
  int          cyc;
  int          checks;
  int          errors;

  assign qv_all[0] = qv_a1;
  assign qv_all[1] = qv_a2;
  assign qv_all[2] = qv_b1;
  assign qv_all[3] = qv_b2;
  assign q_all[0]  = q_a1;
  assign q_all[1]  = q_a2;
  assign q_all[2]  = q_b1;
  assign q_all[3]  = q_b2;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic modelReset();
    for (int w = 0; w < 6; w++) model_mem[w] = 16'h0;
    model_busy = 1'b0;
    model_ptr  = 0;
    for (int c = 0; c < 4; c++) sbq[c].delete();
  endtask

  // Called just after a falling edge: drive inputs, let the rising edge
  // happen, advance the model for that edge, then return at the next fall.
  task automatic applyStimulus(
    input logic clr_i,
    input logic rd1, input logic wr1, input logic [1:0] b1, input logic [2:0] a1, input logic [15:0] d1,
    input logic rd2, input logic wr2, input logic [1:0] b2, input logic [2:0] a2, input logic [15:0] d2);
    logic        pr [2];
    logic        pw [2];
    logic [1:0]  pb [2];
    logic [2:0]  pa [2];
    logic [15:0] pd [2];
    logic [15:0] nm [6];
    exp_t        e;
    clr = clr_i;
    rden_1 = rd1; wren_1 = wr1; be_1 = b1; addr_1 = a1; data_1 = d1;
    rden_2 = rd2; wren_2 = wr2; be_2 = b2; addr_2 = a2; data_2 = d2;
    pr[0] = rd1; pw[0] = wr1; pb[0] = b1; pa[0] = a1; pd[0] = d1;
    pr[1] = rd2; pw[1] = wr2; pb[1] = b2; pa[1] = a2; pd[1] = d2;
    @(posedge clk);
    if (model_busy) begin
      model_mem[model_ptr] = 16'h0;
      if (model_ptr == 5) begin
        model_busy = 1'b0;
        model_ptr  = 0;
      end else begin
        model_ptr++;
      end
    end else begin
      nm = model_mem;
      for (int p = 1; p >= 0; p--) begin
        if (pw[p] && pa[p] < 3'd6) begin
          if (pb[p][0]) nm[pa[p]][7:0]  = pd[p][7:0];
          if (pb[p][1]) nm[pa[p]][15:8] = pd[p][15:8];
        end
      end
      for (int p = 0; p < 2; p++) begin
        if (pr[p] && !pw[p]) begin
          e.data = (pa[p] < 3'd6) ? model_mem[pa[p]] : 16'h0;
          e.due  = cyc + 3;
          sbq[p].push_back(e);
          e.data = (pa[p] < 3'd6) ? nm[pa[p]] : 16'h0;
          e.due  = cyc + 1;
          sbq[p+2].push_back(e);
        end
      end
      model_mem = nm;
      if (clr_i) model_busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(0, 0, 0, 2'b00, 3'd0, 16'h0, 0, 0, 2'b00, 3'd0, 16'h0);
    end
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy_a"}, {31'b0, busy_a}, 32'h0);
    checkOutput({tag, "_busy_b"}, {31'b0, busy_b}, 32'h0);
    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("%s_q_ch%0d", tag, c), {16'b0, q_all[c]}, 32'h0);
      checkOutput($sformatf("%s_qv_ch%0d", tag, c), {31'b0, qv_all[c]}, 32'h0);
    end
  endtask

  // Scoreboard: every read result must arrive exactly on its due cycle,
  // and no strobe may appear without a pending prediction.
  always @(negedge clk) begin
    if (rstb === 1'b1) begin
      for (int c = 0; c < 4; c++) begin
        if (sbq[c].size() > 0 && sbq[c][0].due == cyc) begin
          checkOutput($sformatf("qv_ch%0d", c), {31'b0, qv_all[c]}, 32'h1);
          checkOutput($sformatf("q_ch%0d", c), {16'b0, q_all[c]}, {16'b0, sbq[c][0].data});
          void'(sbq[c].pop_front());
        end else if (qv_all[c] !== 1'b0) begin
          checkOutput($sformatf("qv_unexpected_ch%0d", c), {31'b0, qv_all[c]}, 32'h0);
        end
      end
      checkOutput("busy_a", {31'b0, busy_a}, {31'b0, model_busy});
      checkOutput("busy_b", {31'b0, busy_b}, {31'b0, model_busy});
    end
  end

  initial begin
    checks = 0;
    errors = 0;
    cyc    = 0;
    rstb   = 1'b0;
    clr = 0; rden_1 = 0; wren_1 = 0; be_1 = 0; addr_1 = 0; data_1 = 0;
    rden_2 = 0; wren_2 = 0; be_2 = 0; addr_2 = 0; data_2 = 0;
    modelReset();

    #12;
    checkResetOutputs("reset");
    @(negedge clk);
    rstb = 1'b1;

    // Write then read one cycle later on the other port
    applyStimulus(0, 0, 1, 2'b11, 3'd3, 16'h00A5, 0, 0, 2'b00, 3'd0, 16'h0);
    applyStimulus(0, 0, 0, 2'b00, 3'd0, 16'h0,    1, 0, 2'b00, 3'd3, 16'h0);
    idleCycles(4);

    // Granule merges; port 1 also asserts rden during its writes (no read)
    applyStimulus(0, 1, 1, 2'b11, 3'd1, 16'h1234, 0, 0, 2'b00, 3'd0, 16'h0);
    applyStimulus(0, 1, 1, 2'b01, 3'd1, 16'hFFEE, 0, 1, 2'b10, 3'd0, 16'hABCD);
    applyStimulus(0, 1, 0, 2'b00, 3'd1, 16'h0,    1, 0, 2'b00, 3'd0, 16'h0);
    idleCycles(4);

    // Cross-port read during write, then read back on both ports
    applyStimulus(0, 0, 1, 2'b11, 3'd5, 16'h0011, 1, 0, 2'b00, 3'd5, 16'h0);
    applyStimulus(0, 1, 0, 2'b00, 3'd5, 16'h0,    1, 0, 2'b00, 3'd5, 16'h0);
    idleCycles(4);

    // Write-write collisions: full overlap, then disjoint granules
    applyStimulus(0, 0, 1, 2'b11, 3'd2, 16'h00AA, 0, 1, 2'b11, 3'd2, 16'h0055);
    applyStimulus(0, 0, 1, 2'b01, 3'd4, 16'h00CC, 0, 1, 2'b10, 3'd4, 16'hBB00);
    applyStimulus(0, 1, 0, 2'b00, 3'd2, 16'h0,    1, 0, 2'b00, 3'd4, 16'h0);
    idleCycles(4);

    // Out-of-range writes ignored, out-of-range reads return 0
    applyStimulus(0, 0, 1, 2'b11, 3'd6, 16'hFFFF, 0, 1, 2'b11, 3'd7, 16'hFFFF);
    applyStimulus(0, 1, 0, 2'b00, 3'd7, 16'h0,    1, 0, 2'b00, 3'd6, 16'h0);

    // Back-to-back reads of every word on both ports
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 2'b00, 3'(i), 16'h0, 1, 0, 2'b00, 3'(5 - i), 16'h0);
    end
    idleCycles(4);

    // Fill memory, then clear; the clr edge still executes its requests
    for (int i = 0; i < 3; i++) begin
      applyStimulus(0, 0, 1, 2'b11, 3'(2 * i), 16'h1000 + 16'(i),
                    0, 1, 2'b11, 3'(2 * i + 1), 16'h2000 + 16'(i));
    end
    applyStimulus(1, 1, 0, 2'b00, 3'd0, 16'h0, 0, 1, 2'b11, 3'd1, 16'h7777);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1, 1, 0, 2'b00, 3'd2, 16'h0, 0, 1, 2'b11, 3'd3, 16'hDEAD);
    end
    for (int i = 0; i < 6; i++) begin
      applyStimulus(0, 1, 0, 2'b00, 3'(i), 16'h0, 1, 0, 2'b00, 3'(5 - i), 16'h0);
    end
    idleCycles(4);

    // Reset asserted mid-clear with a read still in flight
    applyStimulus(0, 0, 1, 2'b11, 3'd3, 16'h3333, 0, 0, 2'b00, 3'd0, 16'h0);
    applyStimulus(1, 1, 0, 2'b00, 3'd3, 16'h0,    0, 0, 2'b00, 3'd0, 16'h0);
    idleCycles(1);
    #2;
    rstb = 1'b0;
    #1;
    checkResetOutputs("midclear_reset");
    modelReset();
    @(negedge clk);
    rstb = 1'b1;
    applyStimulus(0, 1, 0, 2'b00, 3'd3, 16'h0, 1, 0, 2'b00, 3'd1, 16'h0);
    idleCycles(5);

    for (int c = 0; c < 4; c++) begin
      checkOutput($sformatf("drain_ch%0d", c), sbq[c].size(), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
